// File: rtl/ring_pkg.sv
// Shared types and constants for ring-counter consumers.
// Latency: n/a (package only).
// Backpressure: n/a.
package ring_pkg;

  localparam int RING_W_DEFAULT = 4;

  // Monitor state encoding (legacy-compatible constant style).
  typedef logic [1:0] state_t;
  localparam state_t SYNC   = 2'd0;
  localparam state_t LOCKED = 2'd1;
  localparam state_t FAULT  = 2'd2;

  // Sticky fault codes.
  localparam logic [1:0] FC_NONE   = 2'b00;
  localparam logic [1:0] FC_ONEHOT = 2'b01;
  localparam logic [1:0] FC_STEP   = 2'b10;

endpackage

// File: rtl/ring_onehot_dec.sv
// One-hot qualifier and binary index encoder for a ring vector.
// Latency: combinational (0 cycles).
// Backpressure: none; pure function of ring_in.
module ring_onehot_dec #(
  parameter int RING_W = 4
) (
  input  logic [RING_W-1:0]         ring_in,
  output logic                      onehot,
  output logic [$clog2(RING_W)-1:0] index
);

  localparam logic [RING_W-1:0] ONE = {{(RING_W-1){1'b0}}, 1'b1};

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  // The index is only meaningful when onehot is high.
  always_comb begin
    onehot = (ring_in != '0) && ((ring_in & (ring_in - ONE)) == '0);
    index  = '0;
    for (int i = 0; i < RING_W; i++) begin
      if (ring_in[i]) index = i[$clog2(RING_W)-1:0];
    end
  end

endmodule

// File: rtl/ring_phase_monitor.sv
// Locks onto a rotate-left one-hot ring and reports phase, wrap, revolutions, faults.
// Latency: 1 cycle; the sample taken at edge t shows on the outputs after edge t.
// Backpressure: none; samples every clock. RING_MON_RESYNC_EN lets FAULT re-lock.
module ring_phase_monitor
  import ring_pkg::*;
#(
  parameter int RING_W   = RING_W_DEFAULT,
  parameter int REV_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RING_W-1:0]         ring_in,
  input  logic                      adv,
  input  logic                      clr,
  output logic [$clog2(RING_W)-1:0] phase,
  output logic                      phase_valid,
  output logic                      wrap,
  output logic [REV_W-1:0]          rev_count,
  output logic                      locked,
  output logic                      fault,
  output logic [1:0]                fault_code
);

  localparam int         PH_W   = $clog2(RING_W);
  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

  state_t            state;
  logic [RING_W-1:0] prev;
  logic              have_prev;
  logic [3:0]        streak;

  logic              onehot;
  logic [PH_W-1:0]   idx;
  logic [RING_W-1:0] expected;
  logic              step_ok;
  logic              wrap_hit;
  logic              streak_done;
  logic              tracking;

  ring_onehot_dec #(.RING_W(RING_W)) u_dec (
    .ring_in (ring_in),
    .onehot  (onehot),
    .index   (idx)
  );

  // Next legal sample: rotated previous sample when advancing, unchanged when holding.
  assign expected    = adv ? {prev[RING_W-2:0], prev[RING_W-1]} : prev;
  assign step_ok     = have_prev & onehot & (ring_in == expected);
  assign wrap_hit    = step_ok & adv & prev[RING_W-1] & ring_in[0];
  assign streak_done = step_ok && ((streak + 4'd1) == LOCK_N);

`ifdef RING_MON_RESYNC_EN
  // FAULT counts correct steps just like SYNC so it can climb back to LOCKED.
  assign tracking = (state == SYNC) || (state == FAULT);
`else
  // FAULT is absorbing; only SYNC hunts for lock.
  assign tracking = (state == SYNC);
`endif

  assign locked      = (state == LOCKED);
  assign phase_valid = locked;
  assign fault       = (state == FAULT);

  // Sample history and phase index; these track the input even across clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev      <= '0;
      have_prev <= 1'b0;
      phase     <= '0;
    end else begin
      prev      <= ring_in;
      have_prev <= onehot;
      if (onehot) phase <= idx;
    end
  end

  // Lock state machine with streak counter, sticky fault code and revolution count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= SYNC;
      streak     <= '0;
      fault_code <= FC_NONE;
      rev_count  <= '0;
      wrap       <= 1'b0;
    end else if (clr) begin
      state      <= SYNC;
      streak     <= '0;
      fault_code <= FC_NONE;
      rev_count  <= '0;
      wrap       <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (tracking) begin
        if (!step_ok) begin
          // Broken or restarted sequence: this sample becomes the new base.
          streak <= '0;
        end else if (streak_done) begin
          state  <= LOCKED;
          streak <= '0;
        end else begin
          streak <= streak + 4'd1;
        end
      end else if (state == LOCKED) begin
        // Not-one-hot outranks a bad step in the same sample.
        if (!onehot) begin
          state      <= FAULT;
          fault_code <= FC_ONEHOT;
        end else if (!step_ok) begin
          state      <= FAULT;
          fault_code <= FC_STEP;
        end else if (wrap_hit) begin
          wrap      <= 1'b1;
          rev_count <= rev_count + 1'b1;
        end
      end else if (state != FAULT) begin
        // Unused encoding: fall back to hunting.
        state  <= SYNC;
        streak <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ring_phase_monitor.sv
// Self-checking bench for ring_phase_monitor: directed scenarios plus random stream.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_ring_phase_monitor;

  localparam int RING_W   = 4;
  localparam int REV_W    = 2;
  localparam int LOCK_CNT = 2;
`ifdef RING_MON_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0]       ring_in;
  logic             adv;
  logic             clr;
  logic [1:0]       phase;
  logic             phase_valid;
  logic             wrap;
  logic [REV_W-1:0] rev_count;
  logic             locked;
  logic             fault;
  logic [1:0]       fault_code;

  int checks = 0;
  int passes = 0;

  // Reference model state, kept in terms of positions and flags.
  bit         m_locked, m_fault, m_wrap, m_have;
  int         m_streak, m_rev, m_pidx;
  logic [1:0] m_phase, m_code;

  ring_phase_monitor #(.RING_W(RING_W), .REV_W(REV_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk         (clk),
    .rst         (rst),
    .ring_in     (ring_in),
    .adv         (adv),
    .clr         (clr),
    .phase       (phase),
    .phase_valid (phase_valid),
    .wrap        (wrap),
    .rev_count   (rev_count),
    .locked      (locked),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic void model_reset();
    m_locked = 0; m_fault = 0; m_wrap = 0; m_have = 0;
    m_streak = 0; m_rev = 0; m_pidx = 0;
    m_phase = 2'd0; m_code = 2'd0;
  endfunction

  // One sample of the monitor rules, evaluated on ring positions.
  function automatic void model_step(logic [3:0] r, logic a, logic c);
    bit oh;
    bit ok;
    int idx;
    oh  = ($countones(r) == 1);
    idx = 0;
    for (int i = 0; i < 4; i++) if (r[i]) idx = i;
    ok = m_have && oh && (idx == (m_pidx + (a ? 1 : 0)) % 4);
    m_wrap = 0;
    if (c) begin
      m_locked = 0; m_fault = 0; m_code = 2'd0; m_streak = 0; m_rev = 0;
    end else if (m_locked) begin
      if (!oh) begin
        m_locked = 0; m_fault = 1; m_code = 2'd1;
      end else if (!ok) begin
        m_locked = 0; m_fault = 1; m_code = 2'd2;
      end else if (a && m_pidx == 3 && idx == 0) begin
        m_wrap = 1; m_rev = (m_rev + 1) % 4;
      end
    end else if (!m_fault || RESYNC) begin
      if (ok) begin
        m_streak++;
        if (m_streak == LOCK_CNT) begin
          m_locked = 1; m_fault = 0; m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
    end
    if (oh) m_phase = 2'(idx);
    m_have = oh;
    m_pidx = idx;
  endfunction

  function automatic logic [9:0] mexp();
    return {m_phase, m_locked, m_wrap, 2'(m_rev), m_locked, m_fault, m_code};
  endfunction

  function automatic logic [9:0] obs();
    return {phase, phase_valid, wrap, rev_count, locked, fault, fault_code};
  endfunction

  // Apply one sample, let the edge take it, then settle for observation.
  task automatic cycle(input logic [3:0] r, input logic a, input logic c);
    ring_in = r; adv = a; clr = c;
    @(posedge clk);
    model_step(r, a, c);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ring_in = 4'b0001; adv = 1'b1; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    ring_in = 4'b0010;
    @(posedge clk); #1;
    checks++;
    if (obs() !== 10'b0) $display("FAIL reset_state: got %b want %b", obs(), 10'b0);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lock_wrap();
    logic [3:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      cycle(seq[i], 1'b1, 1'b0);
      checks++;
      if (obs() !== mexp()) $display("FAIL lock_wrap_model step %0d: got %b want %b", i, obs(), mexp());
      else passes++;
      checks++;
      if (locked !== (i >= 2)) $display("FAIL lock_wrap_locked step %0d: got %b want %b", i, locked, (i >= 2));
      else passes++;
    end
    checks++;
    if ({wrap, rev_count, phase} !== {1'b1, 2'd1, 2'd0})
      $display("FAIL lock_wrap_wrap: got %b want %b", {wrap, rev_count, phase}, {1'b1, 2'd1, 2'd0});
    else passes++;
    cycle(4'b0010, 1'b1, 1'b0);
    checks++;
    if (wrap !== 1'b0) $display("FAIL lock_wrap_pulse_width: got %b want 0", wrap);
    else passes++;
  endtask

  task automatic test_hold();
    cycle(4'b0100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0100, 1'b0, 1'b0);
      checks++;
      if ({fault, wrap, phase, rev_count, locked} !== {1'b0, 1'b0, 2'd2, 2'd1, 1'b1})
        $display("FAIL hold cycle %0d: got %b want %b", i, {fault, wrap, phase, rev_count, locked},
                 {1'b0, 1'b0, 2'd2, 2'd1, 1'b1});
      else passes++;
    end
  endtask

  task automatic test_illegal();
    cycle(4'b0110, 1'b1, 1'b0);
    checks++;
    if ({fault, fault_code, locked, phase_valid} !== {1'b1, 2'b01, 1'b0, 1'b0})
      $display("FAIL illegal_fault: got %b want %b", {fault, fault_code, locked, phase_valid}, 5'b10100);
    else passes++;
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0001, 1'b1, 1'b0);
    checks++;
    if (obs() !== mexp()) $display("FAIL illegal_absorb: got %b want %b", obs(), mexp());
    else passes++;
    cycle(4'b0001, 1'b1, 1'b1);
    checks++;
    if ({fault, fault_code, rev_count, locked} !== {1'b0, 2'b00, 2'd0, 1'b0})
      $display("FAIL illegal_clr: got %b want %b", {fault, fault_code, rev_count, locked}, 6'b0);
    else passes++;
  endtask

  task automatic test_bad_step();
    logic [3:0] seq [6];
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0001};
    for (int i = 0; i < 6; i++) cycle(seq[i], 1'b1, 1'b0);
    checks++;
    if ({fault, fault_code} !== {1'b1, 2'b10})
      $display("FAIL bad_step_code: got %b want %b", {fault, fault_code}, 3'b110);
    else passes++;
    cycle(4'b0010, 1'b1, 1'b0);
    cycle(4'b0100, 1'b1, 1'b0);
    checks++;
    if (obs() !== mexp()) $display("FAIL bad_step_after: got %b want %b", obs(), mexp());
    else passes++;
    checks++;
    if (fault_code !== 2'b10) $display("FAIL bad_step_sticky: got %b want 10", fault_code);
    else passes++;
    cycle(4'b1000, 1'b1, 1'b1);
  endtask

  task automatic test_overflow();
    int want [5];
    want = '{1, 2, 3, 0, 1};
    cycle(4'b0001, 1'b1, 1'b1);
    for (int r = 0; r < 5; r++) begin
      for (int p = 1; p <= 4; p++) begin
        cycle(4'(1 << (p % 4)), 1'b1, 1'b0);
      end
      checks++;
      if ({wrap, rev_count} !== {1'b1, 2'(want[r])})
        $display("FAIL overflow rev %0d: got wrap=%b count=%0d want wrap=1 count=%0d", r, wrap, rev_count, want[r]);
      else passes++;
    end
  endtask

  task automatic test_async_reset();
    cycle(4'b0010, 1'b1, 1'b0);
    checks++;
    if (obs() !== mexp()) $display("FAIL async_pre: got %b want %b", obs(), mexp());
    else passes++;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (obs() !== 10'b0) $display("FAIL async_reset: got %b want %b", obs(), 10'b0);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    int g;
    int errs;
    logic [3:0] r;
    logic a, c;
    g = 0;
    errs = 0;
    for (int n = 0; n < 400; n++) begin
      a = ($urandom_range(0, 3) != 0);
      if (a) g = (g + 1) % 4;
      if ($urandom_range(0, 29) == 0) g = $urandom_range(0, 3);
      r = 4'(1 << g);
      if ($urandom_range(0, 24) == 0) r = 4'($urandom_range(0, 15));
      c = ($urandom_range(0, 59) == 0);
      cycle(r, a, c);
      checks++;
      if (obs() !== mexp()) begin
        if (errs < 10) $display("FAIL random cycle %0d: got %b want %b", n, obs(), mexp());
        errs++;
      end else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_lock_wrap();
    test_hold();
    test_illegal();
    test_bad_step();
    test_overflow();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ring_phase_monitor.md
Name: ring_phase_monitor

Overview:
Downstream consumer of the 4-bit ring counter. Samples the one-hot ring vector every clock and locks onto the rotate-left sequence. Once locked it publishes a binary phase index, a wrap strobe and a revolution count. It detects illegal patterns and wrong steps, and reports them through a fault flag and a fault code for sequencers and debug logic further downstream.

Parameters:
RING_W, 4, ring width; must match the upstream counter; >=2.
REV_W, 8, revolution counter width.
LOCK_CNT, 2, consecutive correct steps needed to lock; 1..15.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
ring_in  input  RING_W  one-hot vector from the ring counter
adv  input  1  1 = ring rotates this cycle, 0 = ring holds; tie 1 for a free-running ring
clr  input  1  synchronous clear of fault state; forces SYNC
phase  output  $clog2(RING_W)  binary index of the hot bit
phase_valid  output  1  phase trustworthy (state LOCKED)
wrap  output  1  1-cycle pulse when MSB->LSB rotation is observed while locked
rev_count  output  REV_W  completed revolutions while locked; wraps modulo 2^REV_W
locked  output  1  state == LOCKED
fault  output  1  state == FAULT
fault_code  output  2  00 none, 01 not one-hot, 10 bad step; sticky until clr/rst

Behaviour:
- rst: all outputs 0, state SYNC, have_prev=0, streak=0, prev=0. Effective immediately (asynchronous).
- All outputs are registered. A sample taken at edge t is reflected in the outputs after edge t.
- onehot = exactly one bit of ring_in set.
- expected = adv ? rotl(prev,1) : prev, where rotl(x,1) = {x[RING_W-2:0], x[RING_W-1]}.
- step_ok = have_prev & onehot & (ring_in == expected).
- prev <= ring_in every cycle. have_prev <= onehot.
- phase <= index(ring_in) whenever onehot; it holds otherwise.
- SYNC:
  - not onehot -> streak=0.
  - step_ok -> streak++.
  - onehot but not step_ok -> streak=0, and the sample becomes the new base.
  - streak reaches LOCK_CNT -> LOCKED on that same edge; streak cleared.
- LOCKED:
  - not onehot -> FAULT, fault_code=01.
  - onehot & !step_ok -> FAULT, fault_code=10.
  - step_ok & adv & prev[RING_W-1] & ring_in[0] -> wrap=1 for one cycle, rev_count++.
- FAULT: phase_valid=0, locked=0, wrap=0. rev_count frozen. Exit only via clr (or the optional feature).
- clr: highest priority after rst. Next state SYNC, fault_code=00, streak=0, rev_count=0. The same-cycle sample is taken as the first SYNC sample.
- phase_valid = locked. wrap never asserts outside LOCKED.
- Fault precedence: not-one-hot (01) beats bad-step (10) in the same sample.
- adv=0 with a changing ring_in while locked is a bad step (10).
- Upstream ring reset while this block is not reset (e.g. 0100 -> 0001) is a bad step. The two blocks share rst in the system.
- rev_count overflow wraps silently, e.g. 255 -> 0 for REV_W=8.

Optional Feature:
Macro RING_MON_RESYNC_EN.
- Defined: FAULT tracks streak exactly like SYNC. After LOCK_CNT consecutive step_ok samples it returns to LOCKED: fault deasserts, fault_code stays sticky until clr, rev_count resumes from its frozen value.
- Undefined: FAULT is absorbing until clr or rst.

Decomposition:
- Shared package ring_pkg:
  - state typedef {SYNC, LOCKED, FAULT}.
  - fault code constants FC_NONE=2'b00, FC_ONEHOT=2'b01, FC_STEP=2'b10.
  - default RING_W=4.
- Sub-module ring_onehot_dec: combinational; ring_in -> onehot flag + binary index; parameterised on RING_W. Reused by other ring consumers.

Test Plan:
- Lock and wrap: rst released, ring_in 0001,0010,0100,1000,0001, adv=1, LOCK_CNT=2.
  -> locked=1 after the 3rd edge (0100 sample); phase=2 then 3; wrap=1 for exactly the 0001 sample after 1000; rev_count=1.
- Hold: after lock, adv=0 and ring_in held at 0100 for 3 cycles.
  -> no fault, wrap=0, phase=2 held, rev_count unchanged.
- Illegal pattern: locked, ring_in=0110.
  -> fault=1, fault_code=01, locked=0, phase_valid=0 next cycle.
  -> then ring_in=0000 or 0001 gives no change (without RESYNC); clr=1 for one cycle -> fault=0, fault_code=00, rev_count=0, state SYNC.
- Bad step: locked at 0010, ring_in jumps to 0001 (upstream reset only).
  -> fault_code=10.
  -> with RING_MON_RESYNC_EN: 0010,0100 follow -> locked=1, fault=0, fault_code stays 10.
- Overflow and async reset: REV_W=2, run 5 full revolutions -> rev_count sequence 1,2,3,0,1. Assert rst mid-revolution between edges -> all outputs 0 immediately.
